// File: rtl/nibble_frame_tx.sv
// nibble_frame_tx
//   Transmit side of the packed-nibble operand link. Bytes arrive on a
//   valid/ready port and leave on a 4-bit pin bus as nibble pairs, high
//   nibble first. After every FRAME_LEN bytes one checksum nibble is
//   appended: the mod-16 sum of every nibble in the frame, which matches
//   the nibble-add done by the receiving adder.
//
// Parameters
//   FRAME_LEN    data bytes per frame, 1..15
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high
//   in_data      byte to transmit
//   in_valid     in_data is valid
//   in_ready     block can accept a byte this cycle
//   nib_out      nibble on the pin bus
//   nib_valid    nib_out is valid
//   nib_ready    sink accepts nib_out this cycle
//   nib_sof      current nibble is the first nibble of a frame
//   nib_last     current nibble is the frame checksum
//   frames_sent  completed frame count, wraps 255 -> 0
module nibble_frame_tx #(
  parameter int FRAME_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] nib_out,
  output logic       nib_valid,
  input  logic       nib_ready,
  output logic       nib_sof,
  output logic       nib_last,
  output logic [7:0] frames_sent
);

  typedef enum logic [1:0] {IDLE, HI, LO, CSUM} state_t;

  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] data_q;
  logic [3:0] byte_cnt;
  logic [3:0] csum;

  // Checksum accumulation: 4-bit add, carry discarded (mod 16).
  function automatic logic [3:0] nib_add(input logic [3:0] a, input logic [3:0] b);
    nib_add = a + b;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs decode from state and registers only, so no input reaches an
  // output combinationally.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    nib_valid = 1'b0;
    nib_out   = 4'h0;
    nib_sof   = 1'b0;
    nib_last  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = HI;
      end
      HI: begin
        nib_valid = 1'b1;
        nib_out   = data_q[7:4];
        nib_sof   = (byte_cnt == 4'd0);
        if (nib_ready) state_nxt = LO;
      end
      LO: begin
        nib_valid = 1'b1;
        nib_out   = data_q[3:0];
        if (nib_ready) state_nxt = (byte_cnt == LAST_IDX) ? CSUM : IDLE;
      end
      CSUM: begin
        nib_valid = 1'b1;
        nib_out   = csum;
        nib_last  = 1'b1;
        if (nib_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers. Reset abandons any partial frame, so the running
  // checksum and byte position restart clean.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q      <= 8'h00;
      byte_cnt    <= 4'd0;
      csum        <= 4'h0;
      frames_sent <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) data_q <= in_data;
        end
        HI: begin
          if (nib_ready) csum <= nib_add(csum, data_q[7:4]);
        end
        LO: begin
          if (nib_ready) begin
            csum <= nib_add(csum, data_q[3:0]);
            // On the last byte byte_cnt is left alone; CSUM clears it.
            if (byte_cnt != LAST_IDX) byte_cnt <= byte_cnt + 4'd1;
          end
        end
        CSUM: begin
          if (nib_ready) begin
            csum        <= 4'h0;
            byte_cnt    <= 4'd0;
            frames_sent <= frames_sent + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
